// File: rtl/wt_fetch_sched.sv
// rtl/wt_fetch_sched.sv - weight ROM fetch sequencer: paired row reads into a 2-entry pair FIFO
// Streams rows base..base+num-1 two per cycle from a dual-port 1-cycle ROM to a valid/ready consumer.
module wt_fetch_sched #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 144,
  parameter int DEPTH      = 76
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [ADDR_WIDTH-1:0] mem_addr_a,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  input  logic [DATA_WIDTH-1:0] mem_q_a,
  input  logic [DATA_WIDTH-1:0] mem_q_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_wt_a,
  output logic [DATA_WIDTH-1:0] out_wt_b,
  output logic                  out_b_vld,
  output logic                  out_last
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q, rem_q, addr_a_q, addr_b_q;
  logic                  infl_q, infl_bvld_q, infl_last_q;
  logic                  busy_q, done_q, cfg_err_q;

  logic [DATA_WIDTH-1:0] fa_q [2];
  logic [DATA_WIDTH-1:0] fb_q [2];
  logic                  fbv_q [2];
  logic                  fl_q [2];
  logic [1:0]            cnt_q;
  logic                  wr_q, rd_q;

  logic                  pop, issue, iss_bvld, iss_last, cfg_ok;
  logic [ADDR_WIDTH-1:0] rem_d;

  assign pop    = (cnt_q != 2'd0) && out_ready;
  assign cfg_ok = (num_words != '0) &&
                  (({1'b0, base_addr} + {1'b0, num_words}) <= (ADDR_WIDTH+1)'(DEPTH));

  // Counting this cycle's pop lets a slot freed now be refilled, keeping one pair/cycle
  // while still guaranteeing the pair landing two edges later never finds the FIFO full.
  assign issue    = (state_q == S_RUN) &&
                    (({1'b0, cnt_q} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop}));
  assign iss_bvld = rem_q >= ADDR_WIDTH'(2);
  assign rem_d    = rem_q - (iss_bvld ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1));
  assign iss_last = rem_d == '0;

  assign mem_addr_a = issue ? ptr_q : addr_a_q;
  assign mem_addr_b = issue ? (iss_bvld ? ptr_q + ADDR_WIDTH'(1) : ptr_q) : addr_b_q;

  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign out_valid = cnt_q != 2'd0;
  assign out_wt_a  = fa_q[rd_q];
  assign out_wt_b  = fb_q[rd_q];
  assign out_b_vld = fbv_q[rd_q];
  assign out_last  = fl_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      infl_q      <= 1'b0;
      infl_bvld_q <= 1'b0;
      infl_last_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      infl_q    <= issue;
      if (issue) begin
        infl_bvld_q <= iss_bvld;
        infl_last_q <= iss_last;
        addr_a_q    <= mem_addr_a;
        addr_b_q    <= mem_addr_b;
        ptr_q       <= ptr_q + ADDR_WIDTH'(2);
        rem_q       <= rem_d;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              ptr_q   <= base_addr;
              rem_q   <= num_words;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue && iss_last) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          // The last-tagged pair leaving means nothing remains queued or in flight.
          if (pop && out_last) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fa_q[i]  <= '0;
        fb_q[i]  <= '0;
        fbv_q[i] <= 1'b0;
        fl_q[i]  <= 1'b0;
      end
      cnt_q <= 2'd0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      if (infl_q) begin
        fa_q[wr_q]  <= mem_q_a;
        fb_q[wr_q]  <= mem_q_b;
        fbv_q[wr_q] <= infl_bvld_q;
        fl_q[wr_q]  <= infl_last_q;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_wt_fetch_sched.sv
// tb/tb_wt_fetch_sched.sv - self-checking bench for wt_fetch_sched
module tb_wt_fetch_sched;
  localparam int AW = 11;
  localparam int DW = 144;
  localparam int DEPTH = 76;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_words = '0;
  logic          busy, done, cfg_err;
  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic [DW-1:0] mem_q_a = '0;
  logic [DW-1:0] mem_q_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_wt_a, out_wt_b;
  logic          out_b_vld, out_last;

  int vectors = 0;
  int errs = 0;

  wt_fetch_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b), .mem_q_a(mem_q_a), .mem_q_b(mem_q_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_wt_a(out_wt_a), .out_wt_b(out_wt_b),
    .out_b_vld(out_b_vld), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] row(input int a);
    logic [15:0] t;
    t = 16'(a);
    return {9{t}};
  endfunction

  always @(posedge clk) begin
    mem_q_a <= row(int'(mem_addr_a));
    mem_q_b <= row(int'(mem_addr_b));
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset_check();
    chk("rst_valid", 160'(out_valid), 160'(0));
    chk("rst_busy", 160'(busy), 160'(0));
    chk("rst_done", 160'(done), 160'(0));
    chk("rst_cfg_err", 160'(cfg_err), 160'(0));
    chk("rst_addr_a", 160'(mem_addr_a), 160'(0));
    chk("rst_addr_b", 160'(mem_addr_b), 160'(0));
    chk("rst_wt_a", 160'(out_wt_a), 160'(0));
  endtask

  task automatic cfg_bad(input int base, input int num);
    logic [AW-1:0] aa, ab;
    aa = mem_addr_a;
    ab = mem_addr_b;
    @(negedge clk);
    start = 1'b1; base_addr = AW'(base); num_words = AW'(num);
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_pulse", 160'(cfg_err), 160'(1));
    chk("cfg_err_busy", 160'(busy), 160'(0));
    chk("cfg_err_addr_a", 160'(mem_addr_a), 160'(aa));
    chk("cfg_err_addr_b", 160'(mem_addr_b), 160'(ab));
    @(negedge clk);
    chk("cfg_err_clear", 160'(cfg_err), 160'(0));
    chk("cfg_err_busy2", 160'(busy), 160'(0));
  endtask

  // mode 0: ready always high; 1: ready low for the first 6 cycles; 2: random ready
  task automatic run_job(input int base, input int num, input int mode, input int abort_after,
                         input bit dup);
    int  q_a[$];
    int  q_b[$];
    bit  q_bv[$];
    bit  q_l[$];
    int  hs = 0;
    int  first = -1;
    bit  exp_done = 0;
    bit  finished = 0;
    bit  r;
    for (int off = 0; off < num; off += 2) begin
      q_a.push_back(base + off);
      q_b.push_back(base + off + 1);
      q_bv.push_back(off + 1 < num);
      q_l.push_back(off + 2 >= num);
    end
    @(negedge clk);
    start = 1'b1; base_addr = AW'(base); num_words = AW'(num);
    @(negedge clk);
    start = 1'b0;
    chk("busy_start", 160'(busy), 160'(1));
    chk("cfg_err_ok", 160'(cfg_err), 160'(0));
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start = dup && (cyc == 3);
      if (start) begin base_addr = AW'(0); num_words = AW'(2); end
      if (abort_after != 0 && hs == abort_after) begin
        rst_n = 1'b0;
        #1;
        do_reset_check();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        return;
      end
      chk("done", 160'(done), 160'(exp_done));
      if (exp_done) begin
        chk("busy_end", 160'(busy), 160'(0));
        finished = 1;
        break;
      end
      chk("cfg_err_quiet", 160'(cfg_err), 160'(0));
      if (out_valid && first < 0) first = cyc;
      case (mode)
        0: r = 1'b1;
        1: r = (cyc >= 6);
        default: r = ($urandom_range(0, 99) < 65);
      endcase
      if (mode == 1 && cyc == 5) begin
        chk("held_valid", 160'(out_valid), 160'(1));
        chk("held_head_a", 160'(out_wt_a), 160'(row(q_a[0])));
        chk("held_addr_a", 160'(mem_addr_a), 160'(base + 2));
        chk("held_addr_b", 160'(mem_addr_b), 160'(base + 3));
      end
      out_ready = r;
      if (out_valid && r) begin
        if (q_a.size() == 0) begin
          chk("extra_pair", 160'(1), 160'(0));
        end else begin
          chk("pair_a", 160'(out_wt_a), 160'(row(q_a[0])));
          chk("pair_bvld", 160'(out_b_vld), 160'(q_bv[0]));
          if (q_bv[0]) chk("pair_b", 160'(out_wt_b), 160'(row(q_b[0])));
          chk("pair_last", 160'(out_last), 160'(q_l[0]));
          exp_done = q_l[0];
          void'(q_a.pop_front()); void'(q_b.pop_front());
          void'(q_bv.pop_front()); void'(q_l.pop_front());
          hs++;
        end
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    chk("job_finished", 160'(finished), 160'(1));
    chk("pairs_left", 160'(q_a.size()), 160'(0));
    if (mode == 0) chk("first_valid_latency", 160'(first), 160'(2));
  endtask

  initial begin
    #2;
    do_reset_check();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_job(10, 5, 0, 0, 0);
    run_job(0, 4, 1, 0, 0);
    cfg_bad(70, 7);
    cfg_bad(5, 0);
    run_job(70, 6, 0, 0, 0);
    run_job(75, 1, 0, 0, 0);
    run_job(20, 10, 0, 2, 0);
    run_job(5, 6, 2, 0, 0);
    run_job(30, 9, 2, 0, 1);
    for (int k = 0; k < 6; k++) begin
      int n, b;
      n = $urandom_range(1, 20);
      b = $urandom_range(0, DEPTH - n);
      run_job(b, n, 2, 0, k[0]);
    end
    for (int k = 0; k < 3; k++) begin
      int b;
      b = $urandom_range(60, 75);
      cfg_bad(b, DEPTH + 1 - b + $urandom_range(0, 3));
    end
    run_job(0, DEPTH, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
